// File: rtl/reflet_timer_pkg.sv
// reflet_timer_pkg: shared constants and types for the Reflet bus timer.
//   - register word indices within the 8-word timer window
//   - CTRL bit positions and the common reset value
//   - packed CTRL register type (run in bit0, auto_reload bit1, int_en bit2)
package reflet_timer_pkg;

  localparam int timer_ctrl_id     = 0;
  localparam int timer_prescale_id = 1;
  localparam int timer_reload_id   = 2;
  localparam int timer_count_id    = 3;
  localparam int timer_status_id   = 4;
  localparam int timer_nregs       = 8;

  localparam int timer_run_bit        = 0;
  localparam int timer_autoreload_bit = 1;
  localparam int timer_inten_bit      = 2;

  localparam int timer_reset = 0;

  // Field order matches the bit positions above (last field is bit0).
  typedef struct packed {
    logic int_en;
    logic auto_reload;
    logic run;
  } timer_ctrl_t;

endpackage

// File: rtl/reflet_timer_if.sv
// reflet_timer_if: Reflet CPU system-bus slice seen by a memory-mapped slave.
//   addr     byte address from the CPU
//   data_in  write data (the CPU's data_out)
//   write_en write strobe
//   data_out slave read data, OR-combined into the CPU data_in
// master = CPU side, slave = peripheral side.
interface reflet_timer_if #(
  parameter int wordsize = 16
);
  logic [wordsize-1:0] addr;
  logic [wordsize-1:0] data_in;
  logic                write_en;
  logic [wordsize-1:0] data_out;

  modport master (output addr, output data_in, output write_en, input data_out);
  modport slave  (input addr, input data_in, input write_en, output data_out);
endinterface

// File: rtl/reflet_timer_prescaler.sv
// reflet_timer_prescaler: divides the clock by (prescale+1) while running.
//   clk, reset  clock, synchronous active-low reset
//   enable      low freezes the counter
//   run         low holds the counter at 0
//   clear       restarts the count (CPU wrote CTRL or COUNT)
//   prescale    terminal value; 0 ticks every cycle
//   tick        high in the cycle the counter sits at prescale
module reflet_timer_prescaler #(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                run,
  input  logic                clear,
  input  logic [wordsize-1:0] prescale,
  output logic                tick
);

  logic [wordsize-1:0] pcnt;

  assign tick = run && (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (!reset)
      pcnt <= '0;
    else if (enable) begin
      if (clear || !run || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + wordsize'(1);
    end
  end

endmodule

// File: rtl/reflet_timer.sv
// reflet_timer: memory-mapped down-counting timer on the Reflet system bus.
//   clk, reset  clock, synchronous active-low reset
//   enable      global enable; low freezes all state and ignores the bus
//   bus         slave side of the CPU bus (addr, data_in, write_en, data_out)
//   interrupt   level interrupt = pending & int_en
// Word map from base_addr: 0 CTRL, 1 PRESCALE, 2 RELOAD, 3 COUNT,
// 4 STATUS (bit0 pending, write-1-to-clear), 5-7 read as zero.
module reflet_timer
  import reflet_timer_pkg::*;
#(
  parameter int                  wordsize  = 16,
  parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  reflet_timer_if.slave    bus,
  output logic             interrupt
);

  localparam int                  nbytes = wordsize / 8;
  localparam int                  shift  = $clog2(nbytes);
  localparam logic [wordsize-1:0] window = wordsize'(timer_nregs * nbytes);

  localparam logic [2:0] id_ctrl     = 3'(timer_ctrl_id);
  localparam logic [2:0] id_prescale = 3'(timer_prescale_id);
  localparam logic [2:0] id_reload   = 3'(timer_reload_id);
  localparam logic [2:0] id_count    = 3'(timer_count_id);
  localparam logic [2:0] id_status   = 3'(timer_status_id);

  timer_ctrl_t         ctrl;
  logic [wordsize-1:0] prescale, reload, count;
  logic                pending;
  logic [wordsize-1:0] dout;

  // Unsigned wrap of addr-base_addr also rejects addresses below the base.
  logic [wordsize-1:0] offset;
  logic                sel;
  logic [2:0]          idx;
  assign offset = bus.addr - base_addr;
  assign sel    = offset < window;
  assign idx    = offset[shift +: 3];

  logic wr, wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
  assign wr          = enable && bus.write_en && sel;
  assign wr_ctrl     = wr && (idx == id_ctrl);
  assign wr_prescale = wr && (idx == id_prescale);
  assign wr_reload   = wr && (idx == id_reload);
  assign wr_count    = wr && (idx == id_count);
  assign wr_status   = wr && (idx == id_status);

  logic tick;
  reflet_timer_prescaler #(.wordsize(wordsize)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .run      (ctrl.run),
    .clear    (wr_ctrl || wr_count),
    .prescale (prescale),
    .tick     (tick)
  );

  // A CPU write to COUNT in a tick cycle overrides the tick entirely.
  logic expire;
  assign expire = tick && (count == '0) && !wr_count;

  logic [wordsize-1:0] rdata;
  always_comb begin
    rdata = wordsize'(timer_reset);
    case (idx)
      id_ctrl: begin
        rdata[timer_run_bit]        = ctrl.run;
        rdata[timer_autoreload_bit] = ctrl.auto_reload;
        rdata[timer_inten_bit]      = ctrl.int_en;
      end
      id_prescale: rdata = prescale;
      id_reload:   rdata = reload;
      id_count:    rdata = count;
      id_status:   rdata[0] = pending;
      default:     rdata = wordsize'(timer_reset);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl     <= '0;
      prescale <= wordsize'(timer_reset);
      reload   <= wordsize'(timer_reset);
      count    <= wordsize'(timer_reset);
      pending  <= 1'b0;
      dout     <= '0;
    end else if (enable) begin
      dout <= sel ? rdata : '0;

      if (wr_prescale) prescale <= bus.data_in;
      if (wr_reload)   reload   <= bus.data_in;

      if (wr_count)
        count <= bus.data_in;
      else if (tick) begin
        if (count != '0)
          count <= count - wordsize'(1);
        else if (ctrl.auto_reload)
          count <= reload;
      end

      // Written CTRL beats the one-shot auto-stop.
      if (wr_ctrl) begin
        ctrl.run         <= bus.data_in[timer_run_bit];
        ctrl.auto_reload <= bus.data_in[timer_autoreload_bit];
        ctrl.int_en      <= bus.data_in[timer_inten_bit];
      end else if (expire && !ctrl.auto_reload)
        ctrl.run <= 1'b0;

      // Setting beats a same-cycle clear so no expiry is lost.
      if (expire)
        pending <= 1'b1;
      else if (wr_status && bus.data_in[0])
        pending <= 1'b0;
    end
  end

  assign bus.data_out = dout;
  assign interrupt    = pending && ctrl.int_en;

endmodule

// File: tb/tb_reflet_timer.sv
// tb_reflet_timer: directed scenarios plus randomized bus traffic, all checked
// against a behavioural model of the timer kept in this file.
module tb_reflet_timer;

  localparam int BASE = 'hFF00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic interrupt;

  reflet_timer_if #(.wordsize(16)) bus ();

  reflet_timer #(.wordsize(16), .base_addr(16'hFF00)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer state as plain integers.
  int unsigned m_run = 0, m_ar = 0, m_ie = 0;
  int unsigned m_pre = 0, m_rel = 0, m_cnt = 0, m_pend = 0, m_pcnt = 0;
  int unsigned m_dout = 0;

  task automatic model_step();
    int unsigned off, idx, din;
    bit sel, w, tick, expiry, wc;
    int unsigned n_run, n_ar, n_ie, n_cnt, n_pend, n_pcnt;
    if (!reset) begin
      m_run = 0; m_ar = 0; m_ie = 0; m_pre = 0; m_rel = 0;
      m_cnt = 0; m_pend = 0; m_pcnt = 0; m_dout = 0;
      return;
    end
    if (!enable) return;
    off = (int'(bus.addr) - BASE) & 'hFFFF;
    sel = off < 16;
    idx = off / 2;
    din = bus.data_in;
    w   = bus.write_en && sel;
    wc  = w && idx == 3;

    if (!sel) m_dout = 0;
    else case (idx)
      0: m_dout = m_run + 2 * m_ar + 4 * m_ie;
      1: m_dout = m_pre;
      2: m_dout = m_rel;
      3: m_dout = m_cnt;
      4: m_dout = m_pend;
      default: m_dout = 0;
    endcase

    tick   = m_run == 1 && m_pcnt == m_pre;
    expiry = tick && m_cnt == 0 && !wc;

    n_pcnt = ((w && (idx == 0 || idx == 3)) || m_run == 0 || tick) ? 0 : (m_pcnt + 1) % 65536;

    n_cnt = m_cnt;
    if (wc) n_cnt = din;
    else if (tick) n_cnt = (m_cnt != 0) ? m_cnt - 1 : (m_ar == 1 ? m_rel : 0);

    n_run = m_run; n_ar = m_ar; n_ie = m_ie;
    if (w && idx == 0) begin
      n_run = din & 1; n_ar = (din >> 1) & 1; n_ie = (din >> 2) & 1;
    end else if (expiry && m_ar == 0) n_run = 0;

    n_pend = m_pend;
    if (expiry) n_pend = 1;
    else if (w && idx == 4 && (din & 1) == 1) n_pend = 0;

    if (w && idx == 1) m_pre = din;
    if (w && idx == 2) m_rel = din;
    m_run = n_run; m_ar = n_ar; m_ie = n_ie;
    m_cnt = n_cnt; m_pend = n_pend; m_pcnt = n_pcnt;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("dout", bus.data_out, m_dout);
    chk("irq", interrupt, m_pend & m_ie);
  endtask

  task automatic wr_reg(input int idx, input int val);
    bus.addr = 16'(BASE + 2 * idx);
    bus.data_in = 16'(val);
    bus.write_en = 1'b1;
    cyc();
    bus.write_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input int exp);
    bus.addr = 16'(a);
    bus.write_en = 1'b0;
    cyc();
    chk(tag, bus.data_out, exp);
  endtask

  task automatic idle(input int n);
    bus.addr = 16'(BASE + 6);
    bus.write_en = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int lat;
    int seq[10];
    seq = '{0, 4, 3, 2, 1, 0, 4, 3, 2, 1};
    bus.addr = '0; bus.data_in = '0; bus.write_en = 1'b0;

    // Reset and readback of the whole window.
    cyc(); cyc();
    reset = 1'b1;
    for (int a = BASE; a <= BASE + 8; a += 2) rd_chk("rst_rd", a, 0);
    chk("rst_irq", interrupt, 0);

    // Register read/write and out-of-window reads.
    wr_reg(2, 'h1234);
    rd_chk("reload_rd", BASE + 4, 'h1234);
    rd_chk("unused_rd", BASE + 'hA, 0);
    rd_chk("outside_rd", 'h1000, 0);

    // One-shot: expiry 12 cycles after the CTRL write.
    wr_reg(1, 2); wr_reg(3, 3); wr_reg(0, 'b101);
    lat = 99;
    bus.addr = 16'(BASE + 8);
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (interrupt === 1'b1) begin lat = n; break; end
    end
    chk("oneshot_lat", lat, 12);
    rd_chk("oneshot_ctrl", BASE, 'b100);
    rd_chk("oneshot_cnt", BASE + 6, 0);
    rd_chk("oneshot_pend", BASE + 8, 1);
    chk("oneshot_irq", interrupt, 1);
    wr_reg(4, 1);
    chk("w1c_irq", interrupt, 0);

    // Auto-reload every 5 cycles.
    wr_reg(1, 0); wr_reg(2, 4); wr_reg(3, 0); wr_reg(0, 'b111);
    for (int k = 0; k < 10; k++) rd_chk("ar_seq", BASE + 6, seq[k]);
    idle(1);                  // expiry
    wr_reg(4, 1);             // clear outside expiry
    chk("ar_clr", interrupt, 0);
    idle(3);
    wr_reg(4, 1);             // clear in the expiry cycle
    chk("clr_vs_set", interrupt, 1);

    // COUNT write on a tick cycle wins.
    wr_reg(3, 9);
    rd_chk("cnt_wr_tick", BASE + 6, 9);
    rd_chk("cnt_after", BASE + 6, 8);

    // enable low freezes everything.
    wr_reg(1, 3); wr_reg(3, 50); wr_reg(0, 'b001);
    idle(5);
    enable = 1'b0;
    bus.write_en = 1'b1; bus.data_in = 16'h55;
    for (int i = 0; i < 10; i++) cyc();
    bus.write_en = 1'b0;
    enable = 1'b1;
    rd_chk("frz0", BASE + 6, 49);
    rd_chk("frz1", BASE + 6, 49);
    rd_chk("frz2", BASE + 6, 49);
    rd_chk("frz3", BASE + 6, 48);

    // Reset mid-count clears everything.
    wr_reg(0, 'b101);
    idle(3);
    reset = 1'b0; cyc(); reset = 1'b1;
    for (int a = BASE; a <= BASE + 8; a += 2) rd_chk("midrst_rd", a, 0);
    chk("midrst_irq", interrupt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) < 90);
      reset  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) < 8) bus.addr = 16'(BASE + $urandom_range(0, 15));
      else bus.addr = 16'($urandom);
      bus.write_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 8) bus.data_in = 16'($urandom_range(0, 7));
      else bus.data_in = 16'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
